spi_master_fpga: RTL and testbench
==================================

# spi_master_fpga

FPGA-side SPI master: serialises bytes from a valid/ready stream onto sck/mosi/cs_n and returns the bytes shifted back on miso. It is the initiator for the team's byte-wide SPI slave and uses the same mode-0 convention. The slave loads its MSB onto miso while its bit count is zero, samples mosi on sck rise and shifts miso on sck fall. The block sits between game-logic/test logic and the SPI pins, and all of it runs on the single system clock.

## Interface
Parameters:
- CLK_DIV, default 4 — clk cycles per sck half-period; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on posedge clk.
- reset  in  1  asynchronous, active-high reset.
- tx_valid  in  1  byte offered for transmission.
- tx_data  in  8  byte to send, MSB first.
- tx_ready  out  1  byte accepted on this cycle when tx_valid is also high.
- rx_valid  out  1  one-cycle pulse: rx_data holds a newly received byte.
- rx_data  out  8  last received byte; holds its value between pulses.
- busy  out  1  high whenever the FSM is not in IDLE.
- sck  out  1  SPI clock; idle low.
- mosi  out  1  master-out data.
- miso  in  1  master-in data.
- cs_n  out  1  active-low frame select; low for the whole burst.

## Operation
- Reset values: cs_n=1, sck=0, mosi=0, tx_ready=1 (IDLE), rx_valid=0, rx_data=8'h00, busy=0.
- FSM states: IDLE, LEAD, XFER, TRAIL.
- IDLE:
  - tx_ready=1.
  - On tx_valid: latch tx_data into the shift register, cs_n←0, mosi←tx_data[7], go to LEAD.
- LEAD:
  - Hold sck=0 for CLK_DIV cycles, then go to XFER.
- XFER runs 16 half-periods of CLK_DIV cycles each.
  - Rise edge: sck←1 and sample the miso bit into the shift-register LSB.
  - Fall edge: sck←0 and drive mosi with the next MSB.
- 8th fall edge of a byte:
  - rx_data←the assembled byte and rx_valid pulses for one cycle.
  - tx_ready is high for that single cycle.
  - If tx_valid=1 on that cycle: load the new byte, mosi←new[7], and stay in XFER. There is no sck gap and cs_n stays low.
  - Otherwise go to TRAIL.
- TRAIL:
  - Hold sck=0 for CLK_DIV cycles, then cs_n←1 and go to IDLE.
- tx_ready is 0 in LEAD, TRAIL, and every XFER cycle except the 8th-fall cycle.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary. The divider counter is $clog2(CLK_DIV+1) bits and reloads on every half-period.
- Asynchronous reset mid-transfer:
  - Immediately abort to IDLE with all reset values.
  - The partial byte is discarded and no rx_valid is produced.
- tx_valid deasserting mid-byte is ignored; the byte is already latched.

## Timing
- Times are relative to T0, the clk edge that accepts a byte from IDLE.
- cs_n falls at T0.
- sck rises at T0+CLK_DIV·(1+2k) and falls at T0+CLK_DIV·(2+2k), for k=0..7.
- The miso sample is taken at each rise edge. miso has then been stable for CLK_DIV cycles since the slave's negedge shift.
- rx_valid is high for the cycle following T0+16·CLK_DIV.
- cs_n returns high at T0+17·CLK_DIV.
- busy deasserts together with cs_n.
- In a burst, byte n+1's first rise is at T0+CLK_DIV·(17+16n). sck has a constant period across byte boundaries.
- CLK_DIV=1 is legal: sck=clk/2, and there is 1-cycle lead and trail.

## Configuration
- SPI_MASTER_LOOPBACK_EN defined:
  - The sampled bit is the internal mosi register, not the miso port.
  - Every rx_data equals the tx_data sent in the same byte slot.
  - The miso port exists but is unused.
- Not defined: sampling uses the miso port as described above.

## Structure
- Package spi_pkg holds:
  - the state enum (IDLE, LEAD, XFER, TRAIL);
  - localparam BYTE_BITS=8;
  - the byte_t typedef (logic [7:0]).
- Sub-module spi_clk_gen:
  - CLK_DIV divider that emits one-cycle rise_stb/fall_stb strobes plus the registered sck.
  - Enabled only in XFER and counting CLK_DIV in LEAD/TRAIL.
- The top-level holds the FSM, the shift register and the handshake logic.

## Test plan
- Single byte, CLK_DIV=4, tx_data=8'hA5, slave returns 8'h3C:
  - mosi MSB-first 1,0,1,0,0,1,0,1;
  - 8 sck pulses, period 8 clk;
  - rx_data=8'h3C with one rx_valid pulse;
  - cs_n low from T0 to T0+68.
- Burst 8'h01, 8'h80, 8'hFF with tx_valid held:
  - one cs_n frame of 24 sck pulses with no gap at byte boundaries;
  - three rx_valid pulses;
  - tx_ready high exactly at T0 and the two boundary cycles.
- tx_valid held low: cs_n=1, sck=0, busy=0 and rx_valid never pulses.
- Reset asserted at T0+20 of a byte:
  - immediately cs_n=1, sck=0, mosi=0, busy=0, rx_data=8'h00;
  - no rx_valid;
  - a next byte then transfers normally.
- CLK_DIV=1, tx_data=8'h5A, miso tied high: sck period 2 clk and rx_data=8'hFF.
- With SPI_MASTER_LOOPBACK_EN, miso tied low: each byte returns equal to tx_data (8'hC3 → 8'hC3).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and byte type.
package spi_pkg;
    localparam int BYTE_BITS = 8;

    typedef logic [BYTE_BITS-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } state_t;
endpackage

// File: rtl/spi_clk_gen.sv
// SCK divider: counts CLK_DIV-cycle half-periods while enabled and emits
// one-cycle rise/fall strobes plus the registered sck.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic count_en,
    input  logic sck_en,
    output logic half_stb,
    output logic rise_stb,
    output logic fall_stb,
    output logic sck
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // The end of every half-period is a strobe; only LEAD/XFER turn it into an sck edge.
    assign half_stb = count_en && (cnt == '0);
    assign rise_stb = half_stb && sck_en && !sck;
    assign fall_stb = half_stb && sck_en && sck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= RELOAD;
            sck <= 1'b0;
        end else begin
            if (!count_en || cnt == '0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
            if (rise_stb) begin
                sck <= 1'b1;
            end else if (fall_stb) begin
                sck <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/spi_master_fpga.sv
// Mode-0 byte-stream SPI master with back-to-back burst support.
// Define SPI_MASTER_LOOPBACK_EN to sample the internal mosi instead of miso.
module spi_master_fpga
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);
    state_t     state;
    state_t     state_next;
    byte_t      shreg;
    logic [2:0] bit_cnt;
    logic       half_stb;
    logic       rise_stb;
    logic       fall_stb;
    logic       count_en;
    logic       sck_en;
    logic       last_fall;
    logic       accept;
    logic       sample_bit;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .reset    (reset),
        .count_en (count_en),
        .sck_en   (sck_en),
        .half_stb (half_stb),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .sck      (sck)
    );

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_bit = mosi;
`else
    assign sample_bit = miso;
`endif

    assign last_fall = fall_stb && (bit_cnt == 3'(BYTE_BITS - 1));
    assign accept    = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tx_valid) state_next = LEAD;
            LEAD:    if (rise_stb) state_next = XFER;
            XFER:    if (last_fall && !tx_valid) state_next = TRAIL;
            TRAIL:   if (half_stb) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state == IDLE) || ((state == XFER) && last_fall);
        busy     = (state != IDLE);
        count_en = (state != IDLE);
        sck_en   = (state == LEAD) || (state == XFER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            bit_cnt  <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (state == IDLE && tx_valid) begin
                cs_n    <= 1'b0;
                mosi    <= tx_data[BYTE_BITS-1];
                bit_cnt <= '0;
            end else if (fall_stb) begin
                bit_cnt <= bit_cnt + 3'd1;
                // Byte boundary: publish the byte and chain the next one without an sck gap.
                if (last_fall) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                    if (tx_valid) begin
                        mosi <= tx_data[BYTE_BITS-1];
                    end
                end else begin
                    mosi <= shreg[BYTE_BITS-1];
                end
            end else if (state == TRAIL && half_stb) begin
                cs_n <= 1'b1;
                mosi <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= tx_data;
        end else if (rise_stb) begin
            shreg <= {shreg[BYTE_BITS-2:0], sample_bit};
        end
    end
endmodule

// File: tb/tb_spi_master_fpga.sv
// Bench for spi_master_fpga: per-cycle timing model plus a mode-0 slave model.
module tb_spi_master_fpga;
`ifdef SPI_MASTER_LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       miso;
    logic       tx_valid0, tx_valid1;
    logic       tx_ready0, rx_valid0, busy0, sck0, mosi0, cs_n0;
    logic       tx_ready1, rx_valid1, busy1, sck1, mosi1, cs_n1;
    logic [7:0] rx_data0, rx_data1;
    logic       o_tx_ready, o_rx_valid, o_busy, o_sck, o_mosi, o_cs_n;
    logic [7:0] o_rx_data;
    logic [7:0] tx_b [0:3];
    logic [7:0] resp_b [0:3];
    logic [2:0] sbit = 3'd0;
    logic [1:0] sidx = 2'd0;
    int         tests = 0;
    int         fails = 0;
    int         rx_pulses = 0;

    always #5 clk = ~clk;

    assign tx_valid0 = tx_valid && !sel;
    assign tx_valid1 = tx_valid && sel;

    spi_master_fpga #(.CLK_DIV(4)) dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid0), .tx_data(tx_data),
        .tx_ready(tx_ready0), .rx_valid(rx_valid0), .rx_data(rx_data0), .busy(busy0),
        .sck(sck0), .mosi(mosi0), .miso(miso), .cs_n(cs_n0)
    );

    spi_master_fpga #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid1), .tx_data(tx_data),
        .tx_ready(tx_ready1), .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1),
        .sck(sck1), .mosi(mosi1), .miso(miso), .cs_n(cs_n1)
    );

    assign o_tx_ready = sel ? tx_ready1 : tx_ready0;
    assign o_rx_valid = sel ? rx_valid1 : rx_valid0;
    assign o_rx_data  = sel ? rx_data1  : rx_data0;
    assign o_busy     = sel ? busy1     : busy0;
    assign o_sck      = sel ? sck1      : sck0;
    assign o_mosi     = sel ? mosi1     : mosi0;
    assign o_cs_n     = sel ? cs_n1     : cs_n0;

    // Slave model: MSB presented at bit count zero, shift on every sck fall.
    assign miso = resp_b[sidx][3'd7 - sbit];

    always @(negedge o_sck or posedge o_cs_n) begin
        if (o_cs_n) begin
            sbit = 3'd0;
            sidx = 2'd0;
        end else begin
            sbit = sbit + 3'd1;
            if (sbit == 3'd0) sidx = sidx + 2'd1;
        end
    end

    always @(negedge clk) begin
        if (o_rx_valid) rx_pulses <= rx_pulses + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One cs_n frame of n bytes, checked cycle by cycle against the timing rules.
    task automatic run_frame(input int n);
        int         cd;
        int         idx;
        int         q;
        int         r;
        int         k;
        logic       adv;
        logic       exp_cs, exp_sck, exp_rv, exp_rdy;
        logic [7:0] acc;
        logic [7:0] exp_rx [0:3];
        cd  = sel ? 1 : 4;
        acc = 8'h00;
        for (int j = 0; j < 4; j++) exp_rx[j] = LB ? tx_b[j] : resp_b[j];
        @(negedge clk);
        check("idle_ready", 8'(o_tx_ready), 8'd1);
        tx_data  = tx_b[0];
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        idx = 1;
        if (n > 1) tx_data = tx_b[1];
        else tx_valid = 1'b0;
        for (int d = 0; d <= cd * (16 * n + 1) + 1; d++) begin
            @(negedge clk);
            q       = d / cd;
            r       = d % cd;
            exp_cs  = (d < cd * (16 * n + 1));
            exp_sck = exp_cs && (q % 2 == 1);
            exp_rv  = (d > 0) && (d % (16 * cd) == 0) && (d / (16 * cd) <= n);
            exp_rdy = !exp_cs || (((d + 1) % (16 * cd) == 0) && ((d + 1) / (16 * cd) <= n));
            check($sformatf("cs_n d=%0d", d), 8'(o_cs_n), 8'(!exp_cs));
            check($sformatf("sck d=%0d", d), 8'(o_sck), 8'(exp_sck));
            check($sformatf("busy d=%0d", d), 8'(o_busy), 8'(exp_cs));
            check($sformatf("rx_valid d=%0d", d), 8'(o_rx_valid), 8'(exp_rv));
            check($sformatf("tx_ready d=%0d", d), 8'(o_tx_ready), 8'(exp_rdy));
            if (exp_rv) check($sformatf("rx_data byte%0d", d / (16 * cd) - 1), o_rx_data, exp_rx[d / (16 * cd) - 1]);
            if (exp_sck && r == 0) begin
                k   = (q - 1) / 2;
                acc = {acc[6:0], o_mosi};
                if (k % 8 == 7) check($sformatf("mosi byte%0d", k / 8), acc, tx_b[k / 8]);
            end
            adv = o_tx_ready && tx_valid;
            @(posedge clk);
            #1;
            if (adv) begin
                idx++;
                if (idx < n) tx_data = tx_b[idx];
                else tx_valid = 1'b0;
            end
        end
        check("rx_data_hold", o_rx_data, exp_rx[n - 1]);
    endtask

    initial begin
        int n;
        int rx_before;
        reset    = 1'b1;
        sel      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int j = 0; j < 4; j++) begin
            tx_b[j]   = 8'h00;
            resp_b[j] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst cs_n", 8'(o_cs_n), 8'd1);
        check("rst sck", 8'(o_sck), 8'd0);
        check("rst mosi", 8'(o_mosi), 8'd0);
        check("rst tx_ready", 8'(o_tx_ready), 8'd1);
        check("rst rx_valid", 8'(o_rx_valid), 8'd0);
        check("rst rx_data", o_rx_data, 8'h00);
        check("rst busy", 8'(o_busy), 8'd0);
        reset = 1'b0;

        // Single byte A5 out, 3C back.
        tx_b[0] = 8'hA5; resp_b[0] = 8'h3C;
        run_frame(1);

        // Burst with tx_valid held across byte boundaries.
        tx_b[0] = 8'h01; tx_b[1] = 8'h80; tx_b[2] = 8'hFF;
        for (int j = 0; j < 3; j++) resp_b[j] = 8'($urandom);
        rx_before = rx_pulses;
        run_frame(3);
        check("burst rx pulses", 8'(rx_pulses - rx_before), 8'd3);

        // Idle with tx_valid low.
        rx_before = rx_pulses;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("idle cs_n", 8'(o_cs_n), 8'd1);
            check("idle sck", 8'(o_sck), 8'd0);
            check("idle busy", 8'(o_busy), 8'd0);
        end
        check("idle rx pulses", 8'(rx_pulses - rx_before), 8'd0);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 3);
            for (int j = 0; j < 4; j++) begin
                tx_b[j]   = 8'($urandom);
                resp_b[j] = 8'($urandom);
            end
            run_frame(n);
        end

        // Known nonzero rx_data before the abort.
        tx_b[0] = 8'h96; resp_b[0] = 8'h69;
        run_frame(1);

        // Reset at T0+20 of a byte.
        tx_b[0] = 8'hFF; resp_b[0] = 8'hFF;
        @(negedge clk);
        tx_data  = tx_b[0];
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid  = 1'b0;
        rx_before = rx_pulses;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort cs_n", 8'(o_cs_n), 8'd1);
        check("abort sck", 8'(o_sck), 8'd0);
        check("abort mosi", 8'(o_mosi), 8'd0);
        check("abort busy", 8'(o_busy), 8'd0);
        check("abort rx_data", o_rx_data, 8'h00);
        check("abort tx_ready", 8'(o_tx_ready), 8'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("abort rx pulses", 8'(rx_pulses - rx_before), 8'd0);
        tx_b[0] = 8'($urandom); resp_b[0] = 8'($urandom);
        run_frame(1);

        // CLK_DIV=1, miso high throughout.
        sel = 1'b1;
        tx_b[0] = 8'h5A; resp_b[0] = 8'hFF;
        run_frame(1);
        for (int j = 0; j < 4; j++) begin
            tx_b[j]   = 8'($urandom);
            resp_b[j] = 8'($urandom);
        end
        run_frame(2);
        sel = 1'b0;

        // C3 with a slave that returns zeros.
        tx_b[0] = 8'hC3; resp_b[0] = 8'h00;
        run_frame(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
